// File: rtl/mem_arbiter.sv
// Two-client (I-cache / D-cache) arbiter in front of one shared slow line memory.
// Ties are broken toward the client not served last, so neither cache can starve.
`timescale 1ns/1ps
module mem_arbiter (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_read,
  input  logic         i_write,
  input  logic [27:0]  i_addr,
  input  logic [127:0] i_wdata,
  output logic [127:0] i_rdata,
  output logic         i_ready,
  input  logic         d_read,
  input  logic         d_write,
  input  logic [27:0]  d_addr,
  input  logic [127:0] d_wdata,
  output logic [127:0] d_rdata,
  output logic         d_ready,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

  state_t state, state_next;
  logic   last_d;
  logic   i_req, d_req;
  logic   grant_i, grant_d, done;

  assign i_req = i_read | i_write;
  assign d_req = d_read | d_write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // D wins a tie unless it was the client served most recently.
  always_comb begin
    state_next = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (d_req && (!i_req || !last_d)) begin
          grant_d    = 1'b1;
          state_next = BUSY_D;
        end else if (i_req) begin
          grant_i    = 1'b1;
          state_next = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ready) begin
          done       = 1'b1;
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A client raising both read and write is treated as a write; mem_write
  // doubles as the latched operation for deciding whether to capture read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_d    <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_ready   <= 1'b0;
      d_ready   <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      if (grant_d) begin
        last_d    <= 1'b1;
        mem_read  <= ~d_write;
        mem_write <= d_write;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
      end else if (grant_i) begin
        last_d    <= 1'b0;
        mem_read  <= ~i_write;
        mem_write <= i_write;
        mem_addr  <= i_addr;
        mem_wdata <= i_wdata;
      end else if (done) begin
        mem_read  <= 1'b0;
        mem_write <= 1'b0;
        if (state == BUSY_I) begin
          i_ready <= 1'b1;
          if (!mem_write) i_rdata <= mem_rdata;
        end else begin
          d_ready <= 1'b1;
          if (!mem_write) d_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: the bench plays both caches and the slow memory,
// and checks grant order, strobe timing, ready pulses and reset behaviour.
`timescale 1ns/1ps
module tb_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_read, i_write, d_read, d_write;
  logic [27:0]  i_addr, d_addr;
  logic [127:0] i_wdata, d_wdata;
  logic [127:0] i_rdata, d_rdata;
  logic         i_ready, d_ready;
  logic         mem_read, mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  int errors = 0;
  int checks = 0;

  mem_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_read    (i_read),
    .i_write   (i_write),
    .i_addr    (i_addr),
    .i_wdata   (i_wdata),
    .i_rdata   (i_rdata),
    .i_ready   (i_ready),
    .d_read    (d_read),
    .d_write   (d_write),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_ready   (d_ready),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, ".ctl"}, {124'd0, mem_read, mem_write, i_ready, d_ready}, '0);
    checkOutput({tag, ".addr"}, {100'd0, mem_addr}, '0);
    checkOutput({tag, ".wdata"}, mem_wdata, '0);
    checkOutput({tag, ".i_rdata"}, i_rdata, '0);
    checkOutput({tag, ".d_rdata"}, d_rdata, '0);
  endtask

  // Acts as memory for one transaction: waits for the strobe, holds it for
  // 'delay' cycles, pulses mem_ready, then checks the one-cycle ready pulse.
  task automatic applyStimulus(input string tag, input bit to_d, input bit exp_write,
                               input logic [27:0] exp_addr, input logic [127:0] exp_wdata,
                               input logic [127:0] line, input logic [127:0] exp_line,
                               input int delay, input bit clear_req, input bit toggle_i);
    int waited = 0;
    logic [27:0] saved_i_addr;
    logic [1:0]  exp_strobe;
    exp_strobe = exp_write ? 2'b01 : 2'b10;
    while (!(mem_read || mem_write) && waited < 20) begin
      tick();
      waited++;
    end
    checkOutput({tag, ".strobe"}, {126'd0, mem_read, mem_write}, {126'd0, exp_strobe});
    checkOutput({tag, ".addr"}, {100'd0, mem_addr}, {100'd0, exp_addr});
    if (exp_write) checkOutput({tag, ".wdata"}, mem_wdata, exp_wdata);
    saved_i_addr = i_addr;
    for (int k = 0; k < delay; k++) begin
      if (toggle_i) i_addr = ~i_addr;
      tick();
      checkOutput({tag, ".hold"}, {98'd0, mem_read, mem_write, mem_addr},
                  {98'd0, exp_strobe, exp_addr});
    end
    if (toggle_i) i_addr = saved_i_addr;
    mem_rdata = line;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    checkOutput({tag, ".ready"}, {126'd0, i_ready, d_ready},
                {126'd0, (to_d ? 2'b01 : 2'b10)});
    checkOutput({tag, ".strobe_off"}, {126'd0, mem_read, mem_write}, '0);
    checkOutput({tag, ".rdata"}, to_d ? d_rdata : i_rdata, exp_line);
    if (clear_req) begin
      if (to_d) begin d_read = 1'b0; d_write = 1'b0; end
      else      begin i_read = 1'b0; i_write = 1'b0; end
    end
    tick();
    checkOutput({tag, ".ready_off"}, {126'd0, i_ready, d_ready}, '0);
  endtask

  initial begin
    logic [127:0] line_a5, line_wr, line_c3;
    line_a5 = {16{8'hA5}};
    line_wr = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
    line_c3 = {16{8'hC3}};

    rst_n = 1'b0;
    {i_read, i_write, d_read, d_write, mem_ready} = '0;
    i_addr = '0; d_addr = '0; i_wdata = '0; d_wdata = '0; mem_rdata = '0;
    tick();
    tick();
    checkResetState("reset");
    rst_n = 1'b1;

    // Spurious mem_ready in IDLE
    mem_ready = 1'b1;
    mem_rdata = {16{8'hEE}};
    tick();
    mem_ready = 1'b0;
    checkOutput("spurious.out", {124'd0, mem_read, mem_write, i_ready, d_ready}, '0);
    tick();
    checkOutput("spurious.out2", {124'd0, mem_read, mem_write, i_ready, d_ready}, '0);
    checkOutput("spurious.rdata", i_rdata | d_rdata, '0);

    // Tie after reset: D first, then I; second tie D again
    i_addr = 28'h0000100; d_addr = 28'h0000200;
    i_read = 1'b1; d_read = 1'b1;
    applyStimulus("tie1.d", 1, 0, 28'h0000200, '0, {4{32'h1111_1111}}, {4{32'h1111_1111}}, 2, 1, 0);
    applyStimulus("tie1.i", 0, 0, 28'h0000100, '0, {4{32'h2222_2222}}, {4{32'h2222_2222}}, 1, 1, 0);
    i_read = 1'b1; d_read = 1'b1;
    applyStimulus("tie2.d", 1, 0, 28'h0000200, '0, {4{32'h3333_3333}}, {4{32'h3333_3333}}, 1, 1, 0);
    applyStimulus("tie2.i", 0, 0, 28'h0000100, '0, {4{32'h4444_4444}}, {4{32'h4444_4444}}, 1, 1, 0);

    // D read alone, memory answers after 4 cycles
    d_addr = 28'h0000010; d_read = 1'b1;
    applyStimulus("dread", 1, 0, 28'h0000010, '0, line_a5, line_a5, 4, 1, 0);

    // D write while I keeps requesting and toggles its address
    d_addr = 28'h0000020; d_wdata = line_wr; d_write = 1'b1;
    i_addr = 28'h0000300;
    tick();
    i_read = 1'b1;
    applyStimulus("dwrite", 1, 1, 28'h0000020, line_wr, {4{32'hDEAD_BEEF}}, line_a5, 3, 1, 1);
    applyStimulus("after_dw.i", 0, 0, 28'h0000300, '0, {4{32'h5555_5555}}, {4{32'h5555_5555}}, 1, 1, 0);

    // Both clients request continuously: D,I,D,I,D,I
    d_addr = 28'h0000600; i_addr = 28'h0000700;
    d_read = 1'b1; i_read = 1'b1;
    for (int n = 0; n < 6; n++) begin
      logic [127:0] ln;
      ln = {4{32'hF0F0_0000 + 32'(n)}};
      applyStimulus($sformatf("alt%0d", n), (n % 2) == 0, 0,
                    ((n % 2) == 0) ? 28'h0000600 : 28'h0000700, '0, ln, ln, 1, 0, 0);
    end
    d_read = 1'b0; i_read = 1'b0;

    // Reset two cycles into BUSY_I
    i_addr = 28'h0000040; i_wdata = {4{32'hFFFF_FFFF}}; i_read = 1'b1;
    tick();
    checkOutput("rstbusy.strobe", {127'd0, mem_read}, 128'd1);
    tick();
    rst_n = 1'b0;
    #1;
    checkResetState("rstbusy");
    i_read = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("rstbusy.quiet", {124'd0, mem_read, mem_write, i_ready, d_ready}, '0);
    end
    i_addr = 28'h0000044; i_read = 1'b1;
    applyStimulus("rstbusy.fresh", 0, 0, 28'h0000044, '0, line_c3, line_c3, 2, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
